// File: rtl/two_bit_comparator.sv
// Registered magnitude comparator: one-hot EQ/LT/GT plus |A-B| for unsigned or
// two's-complement operands, with a single-cycle valid pipeline.
module two_bit_comparator #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             cmp_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             EQ,
  output logic             LT,
  output logic             GT,
  output logic [WIDTH-1:0] DIFF
);

  // One extra bit is enough to hold A-B for either interpretation.
  function automatic logic signed [WIDTH:0] extend(input logic [WIDTH-1:0] v,
                                                   input logic sgn);
    extend = {sgn & v[WIDTH-1], v};
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH:0] d);
    logic signed [WIDTH:0] m;
    m = (d < 0) ? -d : d;
    magnitude = m[WIDTH-1:0];
  endfunction

  logic signed [WIDTH:0] a_ext_p0;
  logic signed [WIDTH:0] b_ext_p0;
  logic signed [WIDTH:0] diff_s_p0;
  logic                  eq_p0;
  logic                  lt_p0;

  logic             vld_p1_d, vld_p1_q;
  logic             eq_p1_d,  eq_p1_q;
  logic             lt_p1_d,  lt_p1_q;
  logic             gt_p1_d,  gt_p1_q;
  logic [WIDTH-1:0] diff_p1_d, diff_p1_q;

  always_comb begin
    a_ext_p0  = extend(A, cmp_signed);
    b_ext_p0  = extend(B, cmp_signed);
    diff_s_p0 = a_ext_p0 - b_ext_p0;
    eq_p0     = (A == B);
    lt_p0     = diff_s_p0[WIDTH];

    // Result fields only move on an accepted operand pair, so idle-cycle inputs never leak through.
    vld_p1_d  = in_valid;
    eq_p1_d   = eq_p1_q;
    lt_p1_d   = lt_p1_q;
    gt_p1_d   = gt_p1_q;
    diff_p1_d = diff_p1_q;
    if (in_valid) begin
      eq_p1_d   = eq_p0;
      lt_p1_d   = lt_p0;
      gt_p1_d   = ~eq_p0 & ~lt_p0;
      diff_p1_d = magnitude(diff_s_p0);
    end
  end

  // p0 -> p1 stage boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      eq_p1_q   <= 1'b0;
      lt_p1_q   <= 1'b0;
      gt_p1_q   <= 1'b0;
      diff_p1_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      eq_p1_q   <= eq_p1_d;
      lt_p1_q   <= lt_p1_d;
      gt_p1_q   <= gt_p1_d;
      diff_p1_q <= diff_p1_d;
    end
  end

  assign out_valid = vld_p1_q;
  assign EQ        = eq_p1_q;
  assign LT        = lt_p1_q;
  assign GT        = gt_p1_q;
  assign DIFF      = diff_p1_q;

endmodule

// File: tb/tb_two_bit_comparator.sv
// Bench for two_bit_comparator: directed cases, exhaustive streaming and random
// traffic checked against an integer-arithmetic reference model.
module tb_two_bit_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       cmp_signed;
  logic [1:0] A;
  logic [1:0] B;
  logic       out_valid;
  logic       EQ;
  logic       LT;
  logic       GT;
  logic [1:0] DIFF;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int  m_vld, m_eq, m_lt, m_gt, m_diff;
  bit  m_seen;

  two_bit_comparator #(.WIDTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .cmp_signed(cmp_signed),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .EQ        (EQ),
    .LT        (LT),
    .GT        (GT),
    .DIFF      (DIFF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_int(input logic [1:0] v, input bit sgn);
    if (sgn && v >= 2) return int'(v) - 4;
    return int'(v);
  endfunction

  // Apply one cycle of inputs, advance the model at the edge, then compare.
  task automatic cyc(input bit rn, input bit iv, input bit sg,
                     input logic [1:0] a, input logic [1:0] b, input string tag);
    int av, bv, d;
    rst_n      = rn;
    in_valid   = iv;
    cmp_signed = sg;
    A          = a;
    B          = b;
    @(posedge clk);
    if (!rn) begin
      m_vld = 0; m_eq = 0; m_lt = 0; m_gt = 0; m_diff = 0; m_seen = 0;
    end else if (iv) begin
      av     = to_int(a, sg);
      bv     = to_int(b, sg);
      d      = av - bv;
      m_vld  = 1;
      m_eq   = (av == bv) ? 1 : 0;
      m_lt   = (av <  bv) ? 1 : 0;
      m_gt   = (av >  bv) ? 1 : 0;
      m_diff = (d < 0) ? -d : d;
      m_seen = 1;
    end else begin
      m_vld = 0;
    end
    #1;
    chk({tag, ".vld"},  int'(out_valid), m_vld);
    chk({tag, ".eq"},   int'(EQ),        m_eq);
    chk({tag, ".lt"},   int'(LT),        m_lt);
    chk({tag, ".gt"},   int'(GT),        m_gt);
    chk({tag, ".diff"}, int'(DIFF),      m_diff);
    chk({tag, ".hot"},  int'(EQ) + int'(LT) + int'(GT), m_seen ? 1 : 0);
  endtask

  initial begin
    m_vld = 0; m_eq = 0; m_lt = 0; m_gt = 0; m_diff = 0; m_seen = 0;

    // reset with valid asserted must not capture anything
    cyc(0, 1, 0, 2'b11, 2'b00, "rst0");
    cyc(0, 1, 0, 2'b11, 2'b00, "rst1");

    // directed cases, with absolute expectations alongside the model
    cyc(1, 1, 0, 2'b00, 2'b01, "u_lt");
    chk("u_lt.abs", {out_valid, EQ, LT, GT, DIFF}, 6'b101001);
    cyc(1, 0, 0, 2'b00, 2'b00, "idle0");
    cyc(1, 1, 0, 2'b10, 2'b10, "eq_u");
    cyc(1, 1, 1, 2'b10, 2'b10, "eq_s");
    chk("eq_s.abs", {out_valid, EQ, LT, GT, DIFF}, 6'b110000);
    cyc(1, 1, 0, 2'b10, 2'b01, "u_gt");
    chk("u_gt.abs", {out_valid, EQ, LT, GT, DIFF}, 6'b100101);
    cyc(1, 1, 1, 2'b10, 2'b01, "s_lt");
    chk("s_lt.abs", {out_valid, EQ, LT, GT, DIFF}, 6'b101011);

    // exhaustive back-to-back streaming over both modes
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 16; i++)
        cyc(1, 1, m[0], i[3:2], i[1:0], "exh");

    // hold then reset mid-stream
    cyc(1, 1, 0, 2'b11, 2'b01, "hold_ld");
    cyc(1, 0, 1, 2'b00, 2'b11, "hold");
    chk("hold.abs", {out_valid, EQ, LT, GT, DIFF}, 6'b000110);
    cyc(1, 1, 1, 2'b01, 2'b10, "pre_rst");
    cyc(0, 1, 1, 2'b01, 2'b10, "mid_rst");
    chk("mid_rst.abs", {out_valid, EQ, LT, GT, DIFF}, 6'b000000);

    // idle cycles with unknown operands must not disturb held results
    cyc(1, 1, 1, 2'b11, 2'b10, "x_ld");
    cyc(1, 0, 0, 2'bxx, 2'bxx, "x_idle");

    // randomized traffic with occasional resets
    for (int k = 0; k < 200; k++) begin
      bit rn, iv, sg;
      logic [1:0] a, b;
      rn = ($urandom_range(0, 15) != 0);
      iv = ($urandom_range(0, 3) != 0);
      sg = 1'($urandom_range(0, 1));
      a  = 2'($urandom_range(0, 3));
      b  = 2'($urandom_range(0, 3));
      cyc(rn, iv, sg, a, b, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
